// File: rtl/proto245_tester.sv
// proto245_tester
// Loopback traffic generator and checker for the proto245s FIFO-side ports.
// It writes a known pattern into the TX FIFO. It then reads the RX FIFO and
// compares each word against an independently regenerated copy of the same
// pattern.
//
// Ports (all in the fifo_clk domain):
//   fifo_clk, fifo_rstn            clock, synchronous active-low reset
//   start, stop                    run control pulses
//   mode                           0 = incrementing, 1 = Galois LFSR
//   tx_len                         words to send, 0 = continuous until stop
//   txfifo_data/_wr/_full          TX FIFO write side
//   rxfifo_rd/_data/_valid/_empty  RX FIFO read side (valid one cycle after rd)
//   busy, done, timeout            run status (done/timeout sticky until start)
//   tx_cnt, rx_cnt, err_cnt        saturating status counters
module proto245_tester #(
  parameter int unsigned       DATA_W        = 8,
  parameter int unsigned       CNT_W         = 32,
  parameter logic [DATA_W-1:0] LFSR_TAPS     = DATA_W'(8'hB8),
  parameter logic [DATA_W-1:0] SEED          = DATA_W'(1),
  parameter int unsigned       DRAIN_TIMEOUT = 1024
) (
  input  logic              fifo_clk,
  input  logic              fifo_rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [CNT_W-1:0]  tx_len,
  output logic [DATA_W-1:0] txfifo_data,
  output logic              txfifo_wr,
  input  logic              txfifo_full,
  output logic              rxfifo_rd,
  input  logic [DATA_W-1:0] rxfifo_data,
  input  logic              rxfifo_valid,
  input  logic              rxfifo_empty,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  tx_cnt,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int unsigned       IDLE_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  // Next pattern word. TX and RX each call this with their own state.
  function automatic logic [DATA_W-1:0] gen_next(input logic m,
                                                 input logic [DATA_W-1:0] cur);
    if (m) return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    return cur + 1'b1;
  endfunction

  // An all-zero LFSR state would lock up, so substitute 1 in LFSR mode.
  function automatic logic [DATA_W-1:0] seed_for(input logic m);
    if (m && (SEED == '0)) return DATA_W'(1);
    return SEED;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   tx_gen_q, tx_gen_d;
  logic [DATA_W-1:0]   rx_gen_q, rx_gen_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                timeout_q, timeout_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                rd_pend_q;
  logic                active;

  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    tx_gen_d  = tx_gen_q;
    rx_gen_d  = rx_gen_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    timeout_d = timeout_q;
    idle_d    = idle_q;
    txfifo_wr = 1'b0;
    rxfifo_rd = 1'b0;

    // The RX checker runs in both RUN and DRAIN. Its generator free-runs and
    // never resyncs to received data, so one dropped word shows as a burst
    // of errors.
    if (active) begin
      rxfifo_rd = !rxfifo_empty;
      if (rxfifo_valid) begin
        rx_cnt_d = sat_inc(rx_cnt_q);
        rx_gen_d = gen_next(mode_q, rx_gen_q);
        if (rxfifo_data != rx_gen_q) err_cnt_d = sat_inc(err_cnt_q);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          mode_d    = mode;
          len_d     = tx_len;
          tx_gen_d  = seed_for(mode);
          rx_gen_d  = seed_for(mode);
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          err_cnt_d = '0;
          timeout_d = 1'b0;
          idle_d    = '0;
        end
      end
      S_RUN: begin
        txfifo_wr = !txfifo_full && ((len_q == '0) || (tx_cnt_q < len_q));
        if (txfifo_wr) begin
          tx_cnt_d = sat_inc(tx_cnt_q);
          tx_gen_d = gen_next(mode_q, tx_gen_q);
        end
        idle_d = '0;
        // Compare the post-write count so DRAIN starts the cycle after the
        // last write, not one cycle later.
        if (((len_q != '0) && (tx_cnt_d == len_q)) || stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        idle_d = rxfifo_valid ? '0 : idle_q + 1'b1;
        if ((rx_cnt_q == tx_cnt_q) && !rd_pend_q) begin
          state_d = S_DONE;
        end else if (!rxfifo_valid && (idle_q == IDLE_LAST)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fifo_clk) begin
    if (!fifo_rstn) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      len_q     <= '0;
      tx_gen_q  <= SEED;
      rx_gen_q  <= SEED;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      timeout_q <= 1'b0;
      idle_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      tx_gen_q  <= tx_gen_d;
      rx_gen_q  <= rx_gen_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      timeout_q <= timeout_d;
      idle_q    <= idle_d;
      // A read issued this cycle returns data next cycle. DRAIN waits for it.
      rd_pend_q <= rxfifo_rd;
    end
  end

  assign txfifo_data = tx_gen_q;
  assign busy        = active;
  assign done        = (state_q == S_DONE);
  assign timeout     = timeout_q;
  assign tx_cnt      = tx_cnt_q;
  assign rx_cnt      = rx_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: doc/proto245_tester.md
# proto245_tester

Synthesizable traffic generator and checker for the proto245s FIFO-side interface, used for on-board loopback self-test.
- Writes a known pattern into the TX FIFO.
- Reads the RX FIFO back and compares each word against an independently regenerated copy of the pattern.
- Sits in the fifo_clk domain, connected directly to proto245s `txfifo_*`/`rxfifo_*` ports, with a host device looping data back over FT245 sync.
- Generalises the simulation-only directed checks with a selectable pattern, programmable length and continuous mode, drain timeout, and saturating status counters.

## Interface
Parameters:
- DATA_W, 8, FIFO word width (≥2)
- CNT_W, 32, width of length and status counters
- LFSR_TAPS, 8'hB8, Galois LFSR feedback mask (DATA_W bits)
- SEED, 1, first pattern word
- DRAIN_TIMEOUT, 1024, idle cycles in DRAIN before giving up

Ports:
- fifo_clk  in  1  clock; single clock domain, all logic on rising edge
- fifo_rstn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse, begins a run
- stop  in  1  pulse, ends TX generation early
- mode  in  1  0 = incrementing pattern, 1 = LFSR pattern
- tx_len  in  CNT_W  words to send; 0 = continuous until stop
- txfifo_data  out  DATA_W  TX word
- txfifo_wr  out  1  TX write strobe
- txfifo_full  in  1  TX FIFO full
- rxfifo_rd  out  1  RX read strobe
- rxfifo_data  in  DATA_W  RX word, qualified by rxfifo_valid
- rxfifo_valid  in  1  RX data valid, one cycle after rxfifo_rd
- rxfifo_empty  in  1  RX FIFO empty
- busy  out  1  run in progress
- done  out  1  run complete, sticky until next start
- timeout  out  1  DRAIN ended by timeout, sticky until next start
- tx_cnt  out  CNT_W  words written
- rx_cnt  out  CNT_W  words received
- err_cnt  out  CNT_W  mismatched words

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE→RUN on start.** On entry:
  - Clear all counters, done and timeout.
  - Latch mode and tx_len.
  - Load both the TX and RX generators with SEED. A SEED of 0 in LFSR mode is replaced by 1.
- **start while busy** is ignored.
- **RUN:**
  - txfifo_wr = !txfifo_full && (len==0 || tx_cnt<len).
  - On each write, tx_cnt increments and the TX generator advances.
  - RUN→DRAIN when tx_cnt==len (len≠0) or stop is seen.
  - stop in IDLE/DONE is ignored.
- **RX (active in RUN and DRAIN):**
  - rxfifo_rd = !rxfifo_empty.
  - On each rxfifo_valid, compare rxfifo_data with the RX generator, increment rx_cnt, and advance the RX generator.
  - A mismatch increments err_cnt.
  - The generator never resyncs to received data.
- **DRAIN:**
  - No writes.
  - Exits to DONE when rx_cnt==tx_cnt and no read is outstanding.
  - Also exits to DONE after DRAIN_TIMEOUT consecutive cycles without rxfifo_valid, setting timeout.
  - Any valid resets the idle counter.
- **DONE:** done=1, busy=0. start→RUN (same as from IDLE).
- **Generators:**
  - Incrementing: next = cur+1, modulo 2^DATA_W, wraps.
  - LFSR: next = (cur>>1) ^ (cur[0] ? LFSR_TAPS : 0).
- **Counters** saturate at all-ones and never wrap.
- **rxfifo_valid outside RUN/DRAIN** is ignored: not counted, not compared.
- **Reset mid-run:** returns to IDLE immediately and clears all state. Words already in the FIFOs are not flushed.

## Timing
- Reset values: txfifo_wr=0, rxfifo_rd=0, txfifo_data=SEED, busy=0, done=0, timeout=0, all counters 0, state IDLE.
- **txfifo_wr and rxfifo_rd** are combinational from registered state and the full/empty inputs. No write is issued in a cycle where full=1; no read in a cycle where empty=1.
- **txfifo_data** is registered and holds the current TX generator value; it advances the cycle after a write.
- **Start latency:** start at cycle N → busy=1 and first possible txfifo_wr at N+1.
- **RUN→DRAIN:** happens the cycle after the last write.
- **Counter updates:** each counter updates the cycle after its qualifying event and is visible on the output the next cycle.
- **done** asserts the cycle after the exit condition; busy deasserts the same cycle.
- **Simultaneous events:**
  - Write and valid in the same cycle update both counters.
  - stop in the same cycle as the final write → DRAIN once; tx_cnt includes that write.

## Test plan
- Loopback model (RX FIFO fed from TX output), mode=0, tx_len=16, SEED=1 → words 1..16 written, done with tx_cnt=rx_cnt=16, err_cnt=0, timeout=0.
- mode=1, tx_len=300, DATA_W=8, taps B8 → LFSR sequence 1,B8,5C,2E,17,B3,… checked; rx_cnt=300, err_cnt=0.
- txfifo_full forced high for 20 cycles mid-run → no txfifo_wr during the stall, txfifo_data held, final tx_cnt=tx_len.
- Loopback corrupts word 5 (XOR 0x01) and word 9 → err_cnt=2, rx_cnt=tx_len.
- tx_len=0, stop after 100 writes, model drops the last 3 words → timeout=1 after 1024 idle cycles, tx_cnt=100, rx_cnt=97.
- fifo_rstn low for one cycle mid-RUN → next cycle busy=0 and all counters 0; a following start runs cleanly.
